code_lock_ctrl: RTL
===================

# code_lock_ctrl

- Four-digit code-entry controller; sits directly upstream of the seven-segment driver.
- User steps a digit with one button and commits it with another. After four digits the block compares the entry against a secret code and shows a result for a fixed hold time.
- Its 4-bit `value` output uses the driver's encoding: 0–9 digit, 10 checkmark, 11 X, 12 blank.

## Interface
- `CODE`, default 16'h1234: secret code, four BCD nibbles; nibble [15:12] is entered first. Each nibble must be ≤ 9.
- `HOLD_CYCLES`, default 10_000_000: cycles the result (or lockout) glyph is held; must be ≥ 1.
- `LOCKOUT_CYCLES`, default 50_000_000: lockout duration; used only with the macro below.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_inc` in 1: asynchronous button level; a rising edge steps the current digit.
- `btn_enter` in 1: asynchronous button level; a rising edge commits the current digit.
- `value` out 4: display code to the seven-segment driver.
- `digit_idx` out 2: index of the digit being entered, 0..3.
- `unlocked` out 1: one-cycle pulse on a correct code.
- `locked_out` out 1: high while in LOCKOUT; constant 0 when the lockout feature is compiled out.

## Operation
- Each button goes through a 2-flop synchronizer, then rising-edge detection. Only the detected edge pulses (`inc_p`, `ent_p`) affect state.
- States: IDLE, ENTRY, RES_OK, RES_ERR, plus LOCKOUT (macro only).
- IDLE
  - `value`=12.
  - Any `inc_p` or `ent_p` → ENTRY with digit=0, idx=0, mismatch=0. That press is consumed and does not step or commit.
- ENTRY
  - `value`=current digit.
  - `inc_p`: digit wraps 9 → 0, otherwise digit+1.
  - `ent_p`: mismatch |= (digit != CODE nibble[idx]).
    - idx<3: idx+1 and digit=0.
    - idx=3: go to RES_OK if the final mismatch is 0, else RES_ERR.
- Simultaneous `inc_p` and `ent_p` in one cycle: the enter wins and the increment is dropped.
- RES_OK: `value`=10. RES_ERR: `value`=11.
  - Each holds for exactly HOLD_CYCLES cycles, then returns to IDLE.
  - All button edges are ignored during the hold.
- `unlocked` is high only in the first cycle of RES_OK.
- `digit_idx` = idx in ENTRY; 0 in all other states.
- Hold counter width is $clog2(HOLD_CYCLES+1). It loads when a result state is entered and counts down to 0.
- `rst` in any state forces IDLE on the next edge and clears digit, idx, mismatch, counters, the fail count and the synchronizer flops.

## Timing
- Reset values: `value`=12, `digit_idx`=0, `unlocked`=0, `locked_out`=0.
- All outputs decode from registered state only; there is no combinational path from the button inputs.
- Latency: a button sampled high at edge E0 (low at E0−1) takes effect at edge E2. The updated `value` is visible after E2.
- A button held high produces exactly one edge. It must be low for ≥1 synchronized cycle to re-arm.
- Result glyph: visible after the edge that enters RES_x, for HOLD_CYCLES cycles; `value`=12 in the following cycle.

## Configuration
- Macro: `CODE_LOCK_LOCKOUT_EN`.
- Defined:
  - A 2-bit consecutive-fail counter increments on each RES_ERR entry and is cleared by RES_OK.
  - When RES_ERR completes with fail count = 3, go to LOCKOUT instead of IDLE.
  - LOCKOUT: `value`=11, `locked_out`=1, buttons ignored for LOCKOUT_CYCLES cycles, then IDLE with fail count cleared.
- Undefined: no fail counter, no LOCKOUT state, `locked_out` tied 0, LOCKOUT_CYCLES unused.

## Structure
- Package `code_lock_pkg`:
  - State enum.
  - Display constants: VAL_CHECK=10, VAL_X=11, VAL_OFF=12.
  - Fail threshold constant: 3.
- Sub-module `btn_sync_edge` (2-flop synchronizer plus rising-edge detector, synchronous reset), instantiated twice.
- `code_lock_ctrl` holds the FSM, counters and comparison. `value` connects directly to the seven-segment driver.

## Test plan
All scenarios use HOLD_CYCLES=8 and LOCKOUT_CYCLES=20.
- After reset: `value`=12, `digit_idx`=0, `unlocked`=0.
- Enter 1,2,3,4 via press sequences → `value`=10 for exactly 8 cycles; `unlocked` pulses once in the first of those cycles; then `value`=12.
- Enter 1,2,3,5 → `value`=11 for 8 cycles, `unlocked` stays 0, then IDLE.
- In ENTRY, press inc 10 times from 0 → `value` returns to 0. Raise inc and enter in the same cycle → idx advances and the digit is not stepped.
- Assert `rst` mid-entry at idx=2 → next cycle `value`=12, `digit_idx`=0. A subsequent correct entry unlocks.
- With `CODE_LOCK_LOCKOUT_EN`: three wrong entries → after the third hold, `locked_out`=1 and `value`=11 for 20 cycles with presses ignored, then IDLE. Without the macro, `locked_out` stays 0.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the four-digit code lock.
// State list grows a LOCKOUT entry when CODE_LOCK_LOCKOUT_EN is defined.
package code_lock_pkg;

`ifdef CODE_LOCK_LOCKOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_RES_OK,
    ST_RES_ERR,
    ST_LOCKOUT
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_RES_OK,
    ST_RES_ERR
  } state_e;
`endif

  localparam logic [3:0] VAL_CHECK   = 4'd10;
  localparam logic [3:0] VAL_X       = 4'd11;
  localparam logic [3:0] VAL_OFF     = 4'd12;
  localparam logic [1:0] FAIL_THRESH = 2'd3;

  // Nibble 0 is the first digit entered (bits [15:12]).
  function automatic logic [3:0] code_nibble(input logic [15:0] code, input logic [1:0] idx);
    logic [3:0] nib;
    nib = code[3:0];
    case (idx)
      2'd0:    nib = code[15:12];
      2'd1:    nib = code[11:8];
      2'd2:    nib = code[7:4];
      default: nib = code[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one button.
// The pulse is decoded from flops only, so it has no path from the raw input.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Four-digit code-entry FSM feeding the seven-segment driver.
// Define CODE_LOCK_LOCKOUT_EN to add the consecutive-failure lockout.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned HOLD_CYCLES    = 10_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_enter,
  output logic [3:0] value,
  output logic [1:0] digit_idx,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic inc_p, ent_p;

  btn_sync_edge u_inc (.clk(clk), .rst(rst), .btn(btn_inc),   .pulse(inc_p));
  btn_sync_edge u_ent (.clk(clk), .rst(rst), .btn(btn_enter), .pulse(ent_p));

  state_e            state_q, state_d;
  logic [3:0]        digit_q, digit_d;
  logic [1:0]        idx_q, idx_d;
  logic              mis_q, mis_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mis_next;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  logic [1:0]        fail_q, fail_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
`else
  logic unused_lockout;
  assign unused_lockout = ^LOCKOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    hold_d   = hold_q;
    mis_next = mis_q | (digit_q != code_nibble(CODE, idx_q));
`ifdef CODE_LOCK_LOCKOUT_EN
    fail_d   = fail_q;
    lock_d   = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The waking press is swallowed; it neither steps nor commits.
        if (inc_p || ent_p) begin
          state_d = ST_ENTRY;
          digit_d = 4'd0;
          idx_d   = 2'd0;
          mis_d   = 1'b0;
        end
      end
      ST_ENTRY: begin
        if (ent_p) begin
          digit_d = 4'd0;
          mis_d   = mis_next;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            hold_d  = HOLD_LOAD;
            state_d = mis_next ? ST_RES_ERR : ST_RES_OK;
`ifdef CODE_LOCK_LOCKOUT_EN
            if (mis_next) fail_d = (fail_q == FAIL_THRESH) ? fail_q : fail_q + 2'd1;
            else          fail_d = 2'd0;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (inc_p) begin
          digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
      end
      ST_RES_OK: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      ST_RES_ERR: begin
        if (hold_q == '0) begin
`ifdef CODE_LOCK_LOCKOUT_EN
          if (fail_q == FAIL_THRESH) begin
            state_d = ST_LOCKOUT;
            lock_d  = LOCK_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_q == '0) begin
          state_d = ST_IDLE;
          fail_d  = 2'd0;
        end else begin
          lock_d = lock_q - LOCK_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      digit_q <= 4'd0;
      idx_q   <= 2'd0;
      mis_q   <= 1'b0;
      hold_q  <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
      fail_q  <= 2'd0;
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      hold_q  <= hold_d;
`ifdef CODE_LOCK_LOCKOUT_EN
      fail_q  <= fail_d;
      lock_q  <= lock_d;
`endif
    end
  end

  // Outputs decode purely from registered state.
  always_comb begin
    value = VAL_OFF;
    case (state_q)
      ST_ENTRY:   value = digit_q;
      ST_RES_OK:  value = VAL_CHECK;
      ST_RES_ERR: value = VAL_X;
`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: value = VAL_X;
`endif
      default:    value = VAL_OFF;
    endcase
  end

  assign digit_idx = (state_q == ST_ENTRY) ? idx_q : 2'd0;
  assign unlocked  = (state_q == ST_RES_OK) && (hold_q == HOLD_LOAD);

`ifdef CODE_LOCK_LOCKOUT_EN
  assign locked_out = (state_q == ST_LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

endmodule
